// File: rtl/reward_deframer_if.sv
// Byte-stream and reward handshake bundle between the UART receiver, the
// reward deframer and the action-value agent.
interface reward_deframer_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_error;
   logic       in_ready;
   logic       reward_valid;
   logic [7:0] reward_data;
   logic       reward_ready;
   logic [7:0] frame_errors;

   modport slave (
      input  in_valid, in_data, in_error, reward_ready,
      output in_ready, reward_valid, reward_data, frame_errors
   );

   modport master (
      output in_valid, in_data, in_error, reward_ready,
      input  in_ready, reward_valid, reward_data, frame_errors
   );
endinterface

// File: rtl/reward_deframer.sv
// Validates SYNC/TAG/REWARD/CHECK frames from the UART byte stream and hands good rewards
// to the agent. Define REWARD_DEFRAMER_SEQUENCE_EN to also require consecutive frame tags.
module reward_deframer #(
   parameter logic [7:0] SYNC    = 8'hA5,
   parameter int         TIMEOUT = 50000
) (
   input logic             clock,
   input logic             reset_n,
   reward_deframer_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, TAG, REWARD, CHECK} state_t;

   function automatic logic [7:0] checksum(input logic [7:0] tag, input logic [7:0] reward);
      return SYNC ^ tag ^ reward;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

   state_t           state;
   logic [7:0]       tag_q;
   logic [7:0]       reward_q;
   logic [CNT_W-1:0] tmo_cnt;
   logic             abort;
   logic             take;
   logic             stall;
   logic             frame_good;
   logic             deliver;
   logic             timeout_hit;
   logic             err_evt;

   // A pending reward only blocks the final byte; earlier bytes never stall the receiver.
   assign stall       = (state == CHECK) && bus.reward_valid && !bus.reward_ready;
   assign bus.in_ready = !stall;

   assign abort       = bus.in_error && (state != IDLE);
   assign take        = bus.in_valid && bus.in_ready && !abort;
   assign frame_good  = (state == CHECK) && take && (bus.in_data == checksum(tag_q, reward_q));
   assign timeout_hit = (state != IDLE) && !take && !abort && bus.in_ready &&
                        (tmo_cnt == CNT_W'(TIMEOUT - 1));

`ifdef REWARD_DEFRAMER_SEQUENCE_EN
   logic [7:0] expected_tag;

   assign deliver = frame_good && (tag_q == expected_tag);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         expected_tag <= 8'h00;
      end else if (frame_good) begin
         expected_tag <= tag_q + 8'd1;
      end
   end
`else
   assign deliver = frame_good;
`endif

   assign err_evt = abort || ((state == CHECK) && take && !deliver) || timeout_hit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         tag_q            <= 8'h00;
         reward_q         <= 8'h00;
         tmo_cnt          <= '0;
         bus.reward_valid <= 1'b0;
         bus.reward_data  <= 8'h00;
         bus.frame_errors <= 8'h00;
      end else begin
         if (err_evt) begin
            bus.frame_errors <= sat_inc(bus.frame_errors);
         end

         // Loading and draining can coincide; a load wins and keeps reward_valid high.
         if (deliver) begin
            bus.reward_valid <= 1'b1;
            bus.reward_data  <= reward_q;
         end else if (bus.reward_valid && bus.reward_ready) begin
            bus.reward_valid <= 1'b0;
         end

         if (abort) begin
            state   <= IDLE;
            tmo_cnt <= '0;
         end else if (take) begin
            tmo_cnt <= '0;
            case (state)
               IDLE:   if (bus.in_data == SYNC) state <= TAG;
               TAG: begin
                  tag_q <= bus.in_data;
                  state <= REWARD;
               end
               REWARD: begin
                  reward_q <= bus.in_data;
                  state    <= CHECK;
               end
               CHECK:  state <= IDLE;
            endcase
         end else if (timeout_hit) begin
            state   <= IDLE;
            tmo_cnt <= '0;
         end else if ((state != IDLE) && bus.in_ready) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_reward_deframer.sv
// Directed bench for reward_deframer with a shortened TIMEOUT; follows
// REWARD_DEFRAMER_SEQUENCE_EN for the tag-sequence section.
module tb_reward_deframer;

   localparam int TMO = 20;

   logic clock = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   rx_count = 0;
   logic [7:0] rx_last = 8'h00;

   reward_deframer_if bus ();

   reward_deframer #(.SYNC(8'hA5), .TIMEOUT(TMO)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   // Record every reward handshake as the agent sees it.
   always @(posedge clock) begin
      if (bus.reward_valid && bus.reward_ready) begin
         rx_count <= rx_count + 1;
         rx_last  <= bus.reward_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (n >= 100) chk("send_stuck", 32'(n), 32'd0);
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] t, input logic [7:0] r, input logic [7:0] c);
      send_byte(8'hA5);
      send_byte(t);
      send_byte(r);
      send_byte(c);
   endtask

   task automatic pulse_error(input logic with_byte, input logic [7:0] b);
      @(negedge clock);
      bus.in_error = 1'b1;
      bus.in_valid = with_byte;
      bus.in_data  = b;
      @(posedge clock);
      #1;
      bus.in_error = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n          = 1'b0;
      bus.in_valid     = 1'b0;
      bus.in_data      = 8'h00;
      bus.in_error     = 1'b0;
      bus.reward_ready = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_valid", 32'(bus.reward_valid), 32'd0);
      chk("rst_data", 32'(bus.reward_data), 32'h00);
      chk("rst_errs", 32'(bus.frame_errors), 32'h00);
      reset_n = 1'b1;

      // Basic frame, reward visible the cycle after CHECK.
      send_frame(8'h00, 8'h3C, 8'h99);
      chk("basic_valid", 32'(bus.reward_valid), 32'd1);
      chk("basic_data", 32'(bus.reward_data), 32'h3C);
      tick();
      chk("basic_rx", 32'(rx_count), 32'd1);
      chk("basic_drain", 32'(bus.reward_valid), 32'd0);
      chk("basic_errs", 32'(bus.frame_errors), 32'h00);

      // Leading noise byte is discarded without counting.
      send_byte(8'h11);
      send_frame(8'h01, 8'h3C, 8'h98);
      tick();
      chk("hunt_rx", 32'(rx_count), 32'd2);
      chk("hunt_data", 32'(rx_last), 32'h3C);
      chk("hunt_errs", 32'(bus.frame_errors), 32'h00);

      // Bad checksum.
      send_frame(8'h01, 8'h7F, 8'h00);
      tick();
      chk("badck_valid", 32'(bus.reward_valid), 32'd0);
      chk("badck_rx", 32'(rx_count), 32'd2);
      chk("badck_errs", 32'(bus.frame_errors), 32'h01);

      // Backpressure: second CHECK byte stalls while 10 is still pending.
      bus.reward_ready = 1'b0;
      send_frame(8'h02, 8'h10, 8'hB7);
      chk("bp_first", 32'(bus.reward_data), 32'h10);
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h20);
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h86;
      chk("bp_stall", 32'(bus.in_ready), 32'd0);
      @(negedge clock);
      chk("bp_stall_hold", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_data", 32'(bus.reward_data), 32'h10);
      chk("bp_hold_valid", 32'(bus.reward_valid), 32'd1);
      bus.reward_ready = 1'b1;
      #1;
      chk("bp_release", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_swap_valid", 32'(bus.reward_valid), 32'd1);
      chk("bp_swap_data", 32'(bus.reward_data), 32'h20);
      chk("bp_rx_first", 32'(rx_last), 32'h10);
      tick();
      chk("bp_rx_second", 32'(rx_last), 32'h20);
      chk("bp_rx_count", 32'(rx_count), 32'd4);
      chk("bp_empty", 32'(bus.reward_valid), 32'd0);

      // Line error wins over a same-cycle byte; errors in IDLE are ignored.
      send_byte(8'hA5);
      send_byte(8'h04);
      pulse_error(1'b1, 8'h55);
      chk("lerr_errs", 32'(bus.frame_errors), 32'h02);
      send_byte(8'hF4);
      pulse_error(1'b0, 8'h00);
      chk("lerr_idle", 32'(bus.frame_errors), 32'h02);
      send_frame(8'h04, 8'h55, 8'hF4);
      tick();
      chk("lerr_recover", 32'(rx_last), 32'h55);
      chk("lerr_rx", 32'(rx_count), 32'd5);

      // Timeout lands exactly TMO cycles after the SYNC byte.
      send_byte(8'hA5);
      repeat (TMO - 1) @(posedge clock);
      #1;
      chk("tmo_early", 32'(bus.frame_errors), 32'h02);
      tick();
      chk("tmo_hit", 32'(bus.frame_errors), 32'h03);
      send_frame(8'h05, 8'h3C, 8'h9C);
      tick();
      chk("tmo_idle_rx", 32'(rx_count), 32'd6);
      chk("tmo_idle_errs", 32'(bus.frame_errors), 32'h03);

      // Saturation.
      for (int i = 0; i < 300; i++) begin
         send_byte(8'hA5);
         pulse_error(1'b0, 8'h00);
      end
      chk("sat_ff", 32'(bus.frame_errors), 32'hFF);
      send_frame(8'h06, 8'h01, 8'h00);
      tick();
      chk("sat_nowrap", 32'(bus.frame_errors), 32'hFF);

      // Asynchronous reset with a pending reward and a partial frame.
      bus.reward_ready = 1'b0;
      send_frame(8'h06, 8'h66, 8'hC5);
      chk("prst_pending", 32'(bus.reward_data), 32'h66);
      send_byte(8'hA5);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.reward_valid), 32'd0);
      chk("arst_data", 32'(bus.reward_data), 32'h00);
      chk("arst_errs", 32'(bus.frame_errors), 32'h00);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clock);
      reset_n = 1'b1;
      bus.reward_ready = 1'b1;

      // Tag sequence run from a fresh reset.
      rx_count = 0;
      send_frame(8'h00, 8'h11, 8'hB4);
      send_frame(8'h01, 8'h22, 8'h86);
      send_frame(8'h03, 8'h33, 8'h95);
      send_frame(8'h04, 8'h44, 8'hE5);
      tick();
`ifdef REWARD_DEFRAMER_SEQUENCE_EN
      chk("seq_rx", 32'(rx_count), 32'd3);
      chk("seq_errs", 32'(bus.frame_errors), 32'h01);
`else
      chk("seq_rx", 32'(rx_count), 32'd4);
      chk("seq_errs", 32'(bus.frame_errors), 32'h00);
`endif
      chk("seq_last", 32'(rx_last), 32'h44);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
